// File: rtl/fcs_pkg.sv
// fcs_pkg: shared FCS definitions for the generator and checker.
// Polynomial, seed, FSM states and the one-bit LFSR step.
package fcs_pkg;

  localparam int         CRC_W_DEF = 8;
  localparam logic [7:0] POLY_DEF  = 8'h07;
  localparam logic [7:0] SEED_DEF  = 8'h00;
  localparam int         CRC_MAX   = 32;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    FCS,
    DONE
  } fcs_state_e;

  // Works on a 32-bit container; w selects the live CRC width.
  function automatic logic [CRC_MAX-1:0] lfsr_step(
    input logic [CRC_MAX-1:0] crc,
    input logic [CRC_MAX-1:0] poly,
    input int                 w,
    input logic               b
  );
    logic [CRC_MAX-1:0] msk;
    logic [CRC_MAX-1:0] nxt;
    logic               fb;
    msk = (w >= CRC_MAX) ? '1
        : ((CRC_MAX'(1) << w) - CRC_MAX'(1));
    fb  = (|(crc & (CRC_MAX'(1) << (w - 1)))) ^ b;
    nxt = ((crc << 1) ^ (fb ? poly : '0)) & msk;
    return nxt;
  endfunction

endpackage

// File: rtl/fcs_lfsr.sv
// fcs_lfsr: serial CRC register.
// load_i restarts from SEED while still absorbing the current bit.
module fcs_lfsr
  import fcs_pkg::*;
#(
  parameter int                   CRC_WIDTH = CRC_W_DEF,
  parameter logic [CRC_WIDTH-1:0] POLY      = POLY_DEF,
  parameter logic [CRC_WIDTH-1:0] SEED      = SEED_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 en_i,
  input  logic                 bit_i,
  output logic [CRC_WIDTH-1:0] crc_o,
  output logic [CRC_WIDTH-1:0] crc_nxt_o
);

  logic [CRC_WIDTH-1:0] crc_q;
  logic [CRC_WIDTH-1:0] crc_d;
  logic [CRC_WIDTH-1:0] base;

  assign base  = load_i ? SEED : crc_q;
  assign crc_d = CRC_WIDTH'(lfsr_step(
                   CRC_MAX'(base),
                   CRC_MAX'(POLY),
                   CRC_WIDTH,
                   bit_i));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= SEED;
    end else if (en_i) begin
      crc_q <= crc_d;
    end
  end

  assign crc_o     = crc_q;
  assign crc_nxt_o = crc_d;

endmodule

// File: rtl/fcs_checker.sv
// fcs_checker: receive-side FCS check of a serial frame.
// Payload then FCS bits go through the LFSR; non-zero residue = error.
module fcs_checker
  import fcs_pkg::*;
#(
  parameter int                   IN_WIDTH  = 1024,
  parameter int                   CRC_WIDTH = CRC_W_DEF,
  parameter logic [CRC_WIDTH-1:0] POLY      = POLY_DEF,
  parameter logic [CRC_WIDTH-1:0] SEED      = SEED_DEF
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [$clog2(IN_WIDTH)-1:0] Data_Size,
  input  logic                        Data_Valid,
  input  logic                        Serial_In,
  output logic                        Busy,
  output logic                        Check_Done,
  output logic                        FCS_Err,
  output logic [CRC_WIDTH-1:0]        Rx_FCS
);

  localparam int DSW = $clog2(IN_WIDTH);
  localparam int PCW = DSW + 1;
  localparam int FCW = $clog2(CRC_WIDTH) + 1;

  fcs_state_e           state_q;
  logic [PCW-1:0]       n_q;
  logic [PCW-1:0]       pcnt_q;
  logic [FCW-1:0]       fcnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic [CRC_WIDTH-1:0] rx_q;

  logic [PCW-1:0]       size_d;
  logic [PCW-1:0]       pcnt_inc;
  logic                 acc;
  logic                 lfsr_load;
  logic [CRC_WIDTH-1:0] crc;
  logic [CRC_WIDTH-1:0] crc_nxt;

  // Zero encodes a full-size frame.
  assign size_d = (Data_Size == '0) ? PCW'(IN_WIDTH)
                                    : {1'b0, Data_Size};

  assign pcnt_inc  = pcnt_q + PCW'(1);
  assign acc       = Data_Valid && (state_q != DONE);
  assign lfsr_load = (state_q == IDLE);

  fcs_lfsr #(
    .CRC_WIDTH (CRC_WIDTH),
    .POLY      (POLY),
    .SEED      (SEED)
  ) u_lfsr (
    .clk       (CLK),
    .rst_n     (RST),
    .load_i    (lfsr_load),
    .en_i      (acc),
    .bit_i     (Serial_In),
    .crc_o     (crc),
    .crc_nxt_o (crc_nxt)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      n_q     <= '0;
      pcnt_q  <= '0;
      fcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rx_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (Data_Valid) begin
            n_q    <= size_d;
            err_q  <= 1'b0;
            busy_q <= 1'b1;
            fcnt_q <= '0;
            if (size_d == PCW'(1)) begin
              pcnt_q  <= '0;
              state_q <= FCS;
            end else begin
              pcnt_q  <= PCW'(1);
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (Data_Valid) begin
            if (pcnt_inc == n_q) begin
              pcnt_q  <= '0;
              fcnt_q  <= '0;
              state_q <= FCS;
            end else begin
              pcnt_q <= pcnt_inc;
            end
          end
        end
        FCS: begin
          if (Data_Valid) begin
            rx_q <= {rx_q[CRC_WIDTH-2:0], Serial_In};
            if (fcnt_q == FCW'(CRC_WIDTH - 1)) begin
              fcnt_q  <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              err_q   <= |crc_nxt;
              state_q <= DONE;
            end else begin
              fcnt_q <= fcnt_q + FCW'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Busy       = busy_q;
  assign Check_Done = done_q;
  assign FCS_Err    = err_q;
  assign Rx_FCS     = rx_q;

endmodule

// File: doc/fcs_checker.md
Name: fcs_checker

Overview:
Receive-side Frame Check Sequence block; the counterpart of the serial FCS generator.
- Accepts a serial frame, MSB first: Data_Size payload bits followed by CRC_WIDTH received FCS bits.
- Runs every bit through the same CRC LFSR the generator uses and flags a mismatch when the residue is non-zero.
- Sits between the serial line receiver and the frame consumer.

Parameters:
IN_WIDTH, 1024, max payload width in bits; sets Data_Size width to $clog2(IN_WIDTH)
CRC_WIDTH, 8, FCS length in bits
POLY, 8'h07, generator polynomial with the implicit top bit omitted (CRC_WIDTH bits)
SEED, 8'h00, LFSR value loaded at frame start (CRC_WIDTH bits)

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  asynchronous active-low reset
Data_Size  input  $clog2(IN_WIDTH)  payload bit count; sampled on the frame's first accepted bit
Data_Valid  input  1  Serial_In is a valid bit this cycle
Serial_In  input  1  serial frame bit, MSB first
Busy  output  1  frame in progress
Check_Done  output  1  one-cycle pulse: frame complete, FCS_Err and Rx_FCS valid
FCS_Err  output  1  1 = residue non-zero (corrupt frame)
Rx_FCS  output  CRC_WIDTH  FCS bits received for the last frame

Behaviour:
- Reset: RST low immediately clears all state. State = IDLE; LFSR = SEED; counters = 0; Busy, Check_Done and FCS_Err = 0; Rx_FCS = 0.
- Reset mid-frame discards the frame. No Check_Done is produced.
- Accepted bit: Data_Valid = 1 on a rising edge. Gaps with Data_Valid = 0 are allowed anywhere; all state holds during a gap.
- LFSR update for each accepted bit b:
  - fb = lfsr[MSB] ^ b
  - lfsr <= {lfsr[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : 0)
  - Applied to payload and FCS bits alike. A good frame leaves lfsr = 0 regardless of SEED.
- Data_Size = 0 encodes IN_WIDTH (full-size frame). Any other value N means N payload bits.
- FSM:
  - IDLE: on an accepted bit, latch Data_Size. Process the bit with lfsr seeded from SEED, not the current value. Bit count = 1. Go to DATA, or go straight to FCS when N = 1.
  - DATA: each accepted bit increments the bit count. On the N-th payload bit, clear the count and go to FCS.
  - FCS: each accepted bit also shifts into Rx_FCS (shift left, new bit in the LSB). On the CRC_WIDTH-th FCS bit, go to DONE.
  - DONE: for one cycle, Check_Done = 1 and FCS_Err = (lfsr != 0). Rx_FCS is final. Return to IDLE.
  - Any Data_Valid bit arriving while in DONE is ignored. The transmitter must leave at least 1 idle cycle between frames.
- Latency: Check_Done rises one cycle after the clock edge that accepts the last FCS bit.
- Hold behaviour:
  - FCS_Err and Rx_FCS hold after Check_Done until the first bit of the next frame.
  - On that first bit, FCS_Err clears to 0 and Rx_FCS holds until FCS bits start shifting.
- Busy = 1 in DATA and FCS; 0 in IDLE and DONE.
- Widths:
  - Payload bit counter is $clog2(IN_WIDTH)+1 bits so it can represent IN_WIDTH.
  - FCS bit counter is $clog2(CRC_WIDTH)+1 bits.
  - Counters never wrap within a legal frame.
- Data_Size changes mid-frame are ignored (latched copy used).

Decomposition:
- Package fcs_pkg holds:
  - default CRC_WIDTH, POLY and SEED
  - the state typedef (IDLE, DATA, FCS, DONE)
  - the shared LFSR step function
- The generator side imports the same package so both ends always agree on the polynomial.
- One sub-module, fcs_lfsr: serial CRC register with load-seed, enable and bit input, parameterised by CRC_WIDTH/POLY/SEED.
- Counters and FSM stay in fcs_checker.

Test Plan:
- Good frame: Data_Size = 72, payload 0x313233343536373839 ("123456789"), then FCS 0xF4, contiguous -> Check_Done one cycle after the last bit, FCS_Err = 0, Rx_FCS = 0xF4.
- Corrupt payload: same frame with payload bit 10 inverted -> FCS_Err = 1, Rx_FCS = 0xF4.
- Corrupt FCS: same payload, FCS 0xF5 -> FCS_Err = 1, Rx_FCS = 0xF5.
- Gapped stream: good frame with Data_Valid deasserted on random cycles (about 30%) -> identical result to the contiguous case; Busy stays 1 through all gaps.
- Boundary sizes: Data_Size = 1 (payload 1'b1, FCS 0x07) and Data_Size = 0 (1024 bits, FCS from the reference model) -> FCS_Err = 0 in both cases; Busy drops in DONE.
- Reset mid-frame: RST low after 40 payload bits, then a fresh good frame -> no Check_Done for the aborted frame; the new frame passes with FCS_Err = 0; back-to-back frames with 1 idle cycle both check correctly.
